mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the processor's single memory port between instruction fetch and the load/store stage (LDB/LDW/STB/STW). Fixed data-side priority with a bounded-starvation guarantee for fetch, byte-lane alignment for byte accesses, and a one-cycle acknowledge per completed access. Sits between the `Proc` pipeline's fetch/memory stages and the unified instruction/data memory.

## Interface
- `ADDR_W`, 32, address width (byte addresses)
- `MAX_D_STREAK`, 4, max consecutive data grants while a fetch is pending
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `if_req`  in  1  fetch request, held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address (word aligned)
- `if_rdata`  out  32  fetched instruction, valid while `if_ack`
- `if_ack`  out  1  one-cycle completion pulse
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_byte`  in  1  1 = byte (LDB/STB), 0 = word (LDW/STW)
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  32  store data (byte in [7:0])
- `d_rdata`  out  32  load result, valid while `d_ack`
- `d_ack`  out  1  one-cycle completion pulse
- `mem_req`  out  1  memory request, held until `mem_ready`
- `mem_we`, `mem_be[3:0]`, `mem_addr[ADDR_W-1:0]`, `mem_wdata[31:0]`  out  memory command
- `mem_rdata`  in  32  memory read data, valid with `mem_ready`
- `mem_ready`  in  1  memory completion, any latency ≥ 0 cycles after `mem_req`
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE: if `d_req` and not (`if_req` and streak == MAX_D_STREAK) → BUSY_D; else if `if_req` → BUSY_I; else stay. The grant latches the command into the registers.
- Streak counter: on a D grant with `if_req` high, streak += 1 (saturating at MAX_D_STREAK). On any I grant, streak = 0. A D grant with `if_req` low clears streak.
- BUSY_x: `mem_req`=1 with the latched command. On `mem_ready`=1, latch the result and go to DONE.
- DONE: the matching ack is 1 for exactly this cycle, then → IDLE. Req inputs are ignored in DONE.
- Word access: `mem_addr` = {addr[ADDR_W-1:2],2'b00}, `mem_be`=4'b1111, data passes through.
- Byte store: `mem_be` = 1<<addr[1:0], `mem_wdata` = byte replicated in all four lanes.
- Byte load: lane addr[1:0] of `mem_rdata`, sign-extended to 32 bits.
- Fetch: always a word read, `mem_we`=0.
- Requester rule: at the edge where ack is high, the requester drops req or presents a new request. Violations (changing fields while req is high and no ack) are undefined.
- Reset: state=IDLE, streak=0. All outputs are 0: `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, both acks, both rdata, `busy`.
- Reset mid-access abandons the access. `mem_req` is 0 the cycle after reset is sampled, and no ack is issued.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Req sampled in IDLE at edge N → `mem_req`=1 in cycle N+1.
- `mem_ready` sampled at edge M → ack + rdata in cycle M+1. Minimum req-to-ack is 2 cycles (zero-wait memory).
- Back-to-back requests: a new grant occurs at the edge after DONE. Maximum throughput is one access per 3 cycles.
- Simultaneous `if_req` and `d_req` in IDLE: D wins, unless the streak limit is reached.
- `mem_ready` while IDLE or DONE is ignored.

## Structure
- Package `mem_arb_pkg`:
  - state enum `arb_state_t` {IDLE, BUSY_I, BUSY_D, DONE}
  - constants for full mask 4'b1111 and lane count 4
- One sub-module `mem_lane_align`: combinational store-replicate/byte-enable generation and load lane select plus sign extension. It is instantiated once and fed from the latched command.

## Test plan
- Reset, then zero-wait memory, `d_req` LDW addr 0x8, memory word 0x12345678 → `mem_req` 1 cycle after the grant, `mem_be`=1111, `d_ack` pulse with `d_rdata`=0x12345678 two cycles after the grant.
- LDB addr 0x6, memory word 0x80FF0011 → `mem_addr`=0x4, `d_rdata`=0xFFFFFFFF. Repeat at addr 0x7 → `d_rdata`=0xFFFFFF80.
- STB addr 0xA, `d_wdata`=0x000000AB → `mem_be`=0100, `mem_wdata`=0xABABABAB, `mem_we`=1.
- `if_req` and `d_req` held continuously with MAX_D_STREAK=4 → grant pattern D,D,D,D,I,D,D,D,D,I, with exactly one ack per grant.
- Memory with 3-cycle `mem_ready` delay, fetch 0x100 → `mem_req` held 4 cycles, `if_ack` one cycle after `mem_ready`, `busy` high throughout.
- `reset` asserted while in BUSY_D → next cycle all outputs are 0 and no `d_ack` is issued. A late `mem_ready` after reset produces no ack.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE
  } arb_state_t;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam int         LANES   = 4;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory port: store replicate + byte enables, load lane select + sign extend.
// Purely combinational; the arbiter registers every result before it leaves the block.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic        st_byte,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  input  logic        ld_byte,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_result
);

  logic [7:0] ld_sel;

  always_comb begin
    st_be    = BE_FULL;
    st_lanes = st_data;
    if (st_byte) begin
      st_be    = 4'b0001 << st_lane;
      st_lanes = {LANES{st_data[7:0]}};
    end
  end

  always_comb begin
    ld_sel = ld_word[7:0];
    for (int i = 0; i < LANES; i++) begin
      if (ld_lane == i[1:0]) ld_sel = ld_word[8*i +: 8];
    end
    ld_result = ld_byte ? sext8(ld_sel) : ld_word;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between fetch and load/store: data first, fetch served after MAX_D_STREAK data grants.
// Grant-to-ack is 2 cycles minimum; requesters hold req until ack, memory stalls via mem_ready.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int              SW         = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_t   state;
  logic [SW-1:0] streak;
  logic         cmd_byte;
  logic [1:0]   cmd_lane;

  logic         fetch_starved;
  logic         grant_d;
  logic [3:0]   st_be;
  logic [31:0]  st_lanes;
  logic [31:0]  ld_result;

  // Fetch word alignment is the requester's job; its low address bits never reach memory.
  logic unused_if_lsb;
  assign unused_if_lsb = ^if_addr[1:0];

  assign fetch_starved = if_req && (streak == STREAK_MAX);
  assign grant_d       = d_req && !fetch_starved;

  // Store side sees the request being granted so byte enables are ready with mem_req;
  // load side sees the lane latched at grant time.
  mem_lane_align u_align (
    .st_byte   (d_byte),
    .st_lane   (d_addr[1:0]),
    .st_data   (d_wdata),
    .st_be     (st_be),
    .st_lanes  (st_lanes),
    .ld_byte   (cmd_byte),
    .ld_lane   (cmd_lane),
    .ld_word   (mem_rdata),
    .ld_result (ld_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      streak    <= '0;
      cmd_byte  <= 1'b0;
      cmd_lane  <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_be    <= st_be;
            mem_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= st_lanes;
            cmd_byte  <= d_byte;
            cmd_lane  <= d_addr[1:0];
            busy      <= 1'b1;
            if (!if_req) begin
              streak <= '0;
            end else if (streak != STREAK_MAX) begin
              streak <= streak + 1'b1;
            end
          end else if (if_req) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= BE_FULL;
            mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= '0;
            cmd_byte  <= 1'b0;
            cmd_lane  <= 2'b00;
            busy      <= 1'b1;
            streak    <= '0;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            state    <= DONE;
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_ack   <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            state   <= DONE;
            mem_req <= 1'b0;
            d_rdata <= ld_result;
            d_ack   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-programmable memory responder.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic        d_byte;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  int   lat         = 0;
  int   wait_cnt    = 0;
  logic force_ready = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .MAX_D_STREAK(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_byte    (d_byte),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy)
  );

  // Memory answers after `lat` cycles of mem_req; force_ready injects stray completions.
  assign mem_ready = force_ready | (mem_req && (wait_cnt >= lat));

  always @(posedge clk) begin
    wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
  end

  task automatic d_issue(input logic we, input logic byt, input logic [31:0] addr,
                         input logic [31:0] wdata);
    d_req   = 1'b1;
    d_we    = we;
    d_byte  = byt;
    d_addr  = addr;
    d_wdata = wdata;
    @(negedge clk);
  endtask

  task automatic wait_d_ack(output int cycles);
    cycles = 0;
    while (!d_ack && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ack, d_ack,
         if_rdata, d_rdata, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b we=%b be=%b addr=%h wdata=%h iack=%b dack=%b irdata=%h drdata=%h busy=%b, want all 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata, busy);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ldw;
    int cyc;
    lat = 0;
    mem_rdata = 32'h1234_5678;
    d_issue(1'b0, 1'b0, 32'h8, 32'h0);
    vectors++;
    if ({mem_req, mem_we, mem_be, mem_addr, busy, d_ack} !== {1'b1, 1'b0, 4'b1111, 32'h8, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL ldw_cmd: got req=%b we=%b be=%b addr=%h busy=%b ack=%b, want 1 0 1111 00000008 1 0",
               mem_req, mem_we, mem_be, mem_addr, busy, d_ack);
    end
    wait_d_ack(cyc);
    vectors++;
    if (cyc !== 1 || d_rdata !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL ldw_ack: got extra_cycles=%0d rdata=%h, want 1 12345678", cyc, d_rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({d_ack, busy, mem_req} !== 3'b000) begin
      miscompares++;
      $display("FAIL ldw_pulse: got ack=%b busy=%b req=%b after ack, want 000", d_ack, busy, mem_req);
    end
  endtask

  task automatic test_ldb;
    int cyc;
    mem_rdata = 32'h80FF_0011;
    d_issue(1'b0, 1'b1, 32'h6, 32'h0);
    vectors++;
    if (mem_addr !== 32'h4) begin
      miscompares++;
      $display("FAIL ldb6_addr: got %h, want 00000004", mem_addr);
    end
    wait_d_ack(cyc);
    vectors++;
    if (cyc !== 1 || d_rdata !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL ldb6_data: got cycles=%0d rdata=%h, want 1 ffffffff", cyc, d_rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
    d_issue(1'b0, 1'b1, 32'h7, 32'h0);
    wait_d_ack(cyc);
    vectors++;
    if (cyc !== 1 || d_rdata !== 32'hFFFF_FF80) begin
      miscompares++;
      $display("FAIL ldb7_data: got cycles=%0d rdata=%h, want 1 ffffff80", cyc, d_rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stb;
    int cyc;
    d_issue(1'b1, 1'b1, 32'hA, 32'h0000_00AB);
    vectors++;
    if ({mem_we, mem_be, mem_wdata, mem_addr} !== {1'b1, 4'b0100, 32'hABAB_ABAB, 32'h8}) begin
      miscompares++;
      $display("FAIL stb_cmd: got we=%b be=%b wdata=%h addr=%h, want 1 0100 abababab 00000008",
               mem_we, mem_be, mem_wdata, mem_addr);
    end
    wait_d_ack(cyc);
    vectors++;
    if (cyc !== 1) begin
      miscompares++;
      $display("FAIL stb_ack: got %0d cycles to ack, want 1", cyc);
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc;
    mem_rdata = 32'h1111_2222;
    d_issue(1'b0, 1'b0, 32'h20, 32'h0);
    wait_d_ack(cyc);
    d_addr    = 32'h24;
    mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    cyc = 1;
    while (!d_ack && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc !== 3 || d_rdata !== 32'h0BAD_F00D || mem_addr !== 32'h24) begin
      miscompares++;
      $display("FAIL back_to_back: got ack_spacing=%0d rdata=%h addr=%h, want 3 0badf00d 00000024",
               cyc, d_rdata, mem_addr);
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_streak;
    logic [9:0] got;
    logic [9:0] want;
    int   acks = 0;
    int   grants = 0;
    int   both = 0;
    int   bad_irdata = 0;
    logic prev_req = 1'b0;
    want = 10'b1111011110;
    got  = '0;
    lat  = 0;
    mem_rdata = 32'h0C0F_FEE0;
    if_req  = 1'b1;
    if_addr = 32'h40;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_byte  = 1'b0;
    d_addr  = 32'h30;
    for (int c = 0; c < 100 && acks < 10; c++) begin
      @(negedge clk);
      if (mem_req && !prev_req) grants++;
      prev_req = mem_req;
      if (d_ack && if_ack) both++;
      if (d_ack || if_ack) begin
        got[9 - acks] = d_ack;
        if (if_ack && if_rdata !== 32'h0C0F_FEE0) bad_irdata++;
        acks++;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL streak_pattern: got %b, want %b (1=D 0=I)", got, want);
    end
    vectors++;
    if (acks !== 10 || grants !== 10 || both !== 0) begin
      miscompares++;
      $display("FAIL streak_acks: got acks=%0d grants=%0d dual=%0d, want 10 10 0", acks, grants, both);
    end
    vectors++;
    if (bad_irdata !== 0) begin
      miscompares++;
      $display("FAIL streak_irdata: got %0d wrong fetch words, want 0", bad_irdata);
    end
    @(negedge clk);
  endtask

  task automatic test_fetch_wait;
    int req_cycles = 0;
    int busy_low = 0;
    int ready_at = -1;
    int ack_at = -1;
    lat       = 3;
    mem_rdata = 32'hDEAD_BEEF;
    if_req    = 1'b1;
    if_addr   = 32'h100;
    @(negedge clk);
    vectors++;
    if ({mem_addr, mem_we, mem_be} !== {32'h100, 1'b0, 4'b1111}) begin
      miscompares++;
      $display("FAIL fetch_cmd: got addr=%h we=%b be=%b, want 00000100 0 1111", mem_addr, mem_we, mem_be);
    end
    for (int c = 0; c < 20 && ack_at < 0; c++) begin
      if (mem_req) req_cycles++;
      if (!busy) busy_low++;
      if (mem_ready && ready_at < 0) ready_at = c;
      if (if_ack) ack_at = c;
      else @(negedge clk);
    end
    if_req = 1'b0;
    vectors++;
    if (req_cycles !== 4 || ready_at !== 3 || ack_at !== 4) begin
      miscompares++;
      $display("FAIL fetch_timing: got req_cycles=%0d ready_at=%0d ack_at=%0d, want 4 3 4",
               req_cycles, ready_at, ack_at);
    end
    vectors++;
    if (busy_low !== 0 || if_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL fetch_result: got busy_low=%0d rdata=%h, want 0 deadbeef", busy_low, if_rdata);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int acks = 0;
    int reqs = 0;
    lat = 1000;
    d_issue(1'b1, 1'b0, 32'h10, 32'h5555_AAAA);
    @(negedge clk);
    vectors++;
    if ({mem_req, busy, d_ack} !== 3'b110) begin
      miscompares++;
      $display("FAIL midreset_pre: got req=%b busy=%b ack=%b, want 110", mem_req, busy, d_ack);
    end
    reset = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ack, d_ack,
         if_rdata, d_rdata, busy} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got req=%b we=%b be=%b addr=%h wdata=%h dack=%b busy=%b, want all 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, d_ack, busy);
    end
    reset       = 1'b0;
    force_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (d_ack || if_ack) acks++;
      if (mem_req) reqs++;
    end
    force_ready = 1'b0;
    vectors++;
    if (acks !== 0 || reqs !== 0) begin
      miscompares++;
      $display("FAIL midreset_late_ready: got acks=%0d req_cycles=%0d, want 0 0", acks, reqs);
    end
    lat = 0;
  endtask

  initial begin
    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_byte    = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    @(negedge clk);
    test_reset;
    test_ldw;
    test_ldb;
    test_stb;
    test_back_to_back;
    test_streak;
    test_fetch_wait;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
